dma_burst_streamer: RTL and testbench

- Splits one DMA transfer descriptor (start address, byte count, mode) into a sequence of AXI-legal burst requests for the DMA AXI master interface.
- Handles INCR/FIXED modes, the configured maximum burst length, AXI 4KB boundaries and a partial final beat.
- One instance drives the read request port and a second drives the write request port; both are sequenced by the DMA FSM through start/abort/done.

---
 rtl/dma_utils_pkg.sv | 30 +++
 rtl/dma_burst_calc.sv | 57 +++++
 rtl/dma_burst_streamer.sv | 168 ++++++++++++++++
 tb/tb_dma_burst_streamer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_utils_pkg.sv
// Shared types and constants for the DMA burst streamer.
package dma_utils_pkg;

    // AXI bursts must not cross a 4KB address boundary.
    localparam int AXI_4KB             = 4096;
    // AXI FIXED bursts are limited to 16 beats.
    localparam int AXI_FIXED_MAX_BEATS = 16;

    // Captured descriptor field widths; the streamer's ADDR_WIDTH and
    // BYTES_WIDTH must not exceed these.
    localparam int CFG_ADDR_W  = 32;
    localparam int CFG_BYTES_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        REQ,
        DONE
    } burst_st_t;

    // While a transfer runs, addr tracks the next burst address and
    // bytes tracks the bytes still to be requested.
    typedef struct packed {
        logic [CFG_ADDR_W-1:0]  addr;
        logic [CFG_BYTES_W-1:0] bytes;
        logic                   mode;
        logic [7:0]             max_alen;
    } s_burst_cfg_t;

endpackage

// File: rtl/dma_burst_calc.sv
// Combinational sizing of the next AXI burst from the current address and
// remaining byte count.
module dma_burst_calc
    import dma_utils_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int BYTES_WIDTH = 32
) (
    input  logic [11:0]             addr_i,
    input  logic [BYTES_WIDTH-1:0]  rem_bytes_i,
    input  logic                    mode_i,
    input  logic [7:0]              max_alen_i,
    output logic [7:0]              alen_o,
    output logic [DATA_WIDTH/8-1:0] strb_o,
    output logic [BYTES_WIDTH-1:0]  bytes_consumed_o
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LG     = $clog2(STRB_W);

    logic [BYTES_WIDTH-1:0] w_full;
    logic [LG-1:0]          w_part;
    logic [12:0]            w_4k_beats;
    logic [12:0]            w_lim;
    logic [12:0]            w_beats;

    // Beat count is the smallest of the remaining full beats, the configured
    // maximum, and the 4KB (INCR) or 16-beat (FIXED) limit; a sub-beat
    // remainder always goes out alone with a partial strobe.
    always_comb begin
        w_full           = rem_bytes_i >> LG;
        w_part           = rem_bytes_i[LG-1:0];
        w_4k_beats       = (13'(AXI_4KB) - {1'b0, addr_i}) >> LG;
        w_lim            = mode_i ? 13'(AXI_FIXED_MAX_BEATS) : w_4k_beats;
        w_beats          = 13'd1;
        strb_o           = '1;
        bytes_consumed_o = '0;
        if (({5'd0, max_alen_i} + 13'd1) < w_lim) begin
            w_lim = {5'd0, max_alen_i} + 13'd1;
        end
        if (w_full == '0) begin
            w_beats          = 13'd1;
            strb_o           = (STRB_W'(1) << w_part) - STRB_W'(1);
            bytes_consumed_o = BYTES_WIDTH'(w_part);
        end else begin
            if (w_full < BYTES_WIDTH'(w_lim)) begin
                w_beats = w_full[12:0];
            end else begin
                w_beats = w_lim;
            end
            strb_o           = '1;
            bytes_consumed_o = BYTES_WIDTH'(w_beats) << LG;
        end
        alen_o = 8'(w_beats - 13'd1);
    end

endmodule

// File: rtl/dma_burst_streamer.sv
// Splits one DMA descriptor into a sequence of AXI-legal burst requests.
module dma_burst_streamer
    import dma_utils_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int BYTES_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [ADDR_WIDTH-1:0]   cfg_addr_i,
    input  logic [BYTES_WIDTH-1:0]  cfg_bytes_i,
    input  logic                    cfg_mode_i,
    input  logic [7:0]              cfg_max_alen_i,
    output logic                    req_valid_o,
    input  logic                    req_ready_i,
    output logic [ADDR_WIDTH-1:0]   req_addr_o,
    output logic [7:0]              req_alen_o,
    output logic [2:0]              req_size_o,
    output logic [DATA_WIDTH/8-1:0] req_strb_o,
    output logic                    req_mode_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_cfg_o
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LG     = $clog2(STRB_W);

    burst_st_t              r_state;
    burst_st_t              w_state_next;
    s_burst_cfg_t           r_cfg;
    logic                   r_abort_pend;
    logic                   r_err;
    logic [ADDR_WIDTH-1:0]  r_req_addr;
    logic [7:0]             r_req_alen;
    logic [STRB_W-1:0]      r_req_strb;
    logic                   r_req_mode;
    logic [2:0]             r_req_size;
    logic [BYTES_WIDTH-1:0] r_consumed;

    logic [7:0]             w_alen;
    logic [STRB_W-1:0]      w_strb;
    logic [BYTES_WIDTH-1:0] w_consumed;
    logic [BYTES_WIDTH-1:0] w_rem_after;
    logic                   w_misaligned;

    assign w_misaligned = (cfg_addr_i[LG-1:0] != '0);
    assign w_rem_after  = r_cfg.bytes[BYTES_WIDTH-1:0] - r_consumed;

    dma_burst_calc #(
        .DATA_WIDTH  (DATA_WIDTH),
        .BYTES_WIDTH (BYTES_WIDTH)
    ) u_calc (
        .addr_i           (r_cfg.addr[11:0]),
        .rem_bytes_i      (r_cfg.bytes[BYTES_WIDTH-1:0]),
        .mode_i           (r_cfg.mode),
        .max_alen_i       (r_cfg.max_alen),
        .alen_o           (w_alen),
        .strb_o           (w_strb),
        .bytes_consumed_o (w_consumed)
    );

    assign req_valid_o = (r_state == REQ);
    assign busy_o      = (r_state != IDLE);
    assign done_o      = (r_state == DONE);
    assign err_cfg_o   = r_err;
    assign req_addr_o  = r_req_addr;
    assign req_alen_o  = r_req_alen;
    assign req_strb_o  = r_req_strb;
    assign req_mode_o  = r_req_mode;
    assign req_size_o  = r_req_size;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a pending abort only takes effect after the
    // in-flight request has completed its handshake.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    if (w_misaligned || (cfg_bytes_i == '0)) begin
                        w_state_next = DONE;
                    end else begin
                        w_state_next = CALC;
                    end
                end
            end
            CALC: begin
                w_state_next = abort_i ? DONE : REQ;
            end
            REQ: begin
                if (req_ready_i) begin
                    if ((w_rem_after == '0) || r_abort_pend || abort_i) begin
                        w_state_next = DONE;
                    end else begin
                        w_state_next = CALC;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Descriptor capture, burst output registers and progress bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cfg        <= '0;
            r_abort_pend <= 1'b0;
            r_err        <= 1'b0;
            r_req_addr   <= '0;
            r_req_alen   <= '0;
            r_req_strb   <= '0;
            r_req_mode   <= 1'b0;
            r_req_size   <= '0;
            r_consumed   <= '0;
        end else begin
            r_req_size <= 3'(LG);
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_cfg.addr     <= CFG_ADDR_W'(cfg_addr_i);
                        r_cfg.bytes    <= CFG_BYTES_W'(cfg_bytes_i);
                        r_cfg.mode     <= cfg_mode_i;
                        r_cfg.max_alen <= cfg_max_alen_i;
                        r_err          <= w_misaligned;
                        r_abort_pend   <= 1'b0;
                    end
                end
                CALC: begin
                    if (!abort_i) begin
                        r_req_addr <= r_cfg.addr[ADDR_WIDTH-1:0];
                        r_req_alen <= w_alen;
                        r_req_strb <= w_strb;
                        r_req_mode <= r_cfg.mode;
                        r_consumed <= w_consumed;
                    end
                end
                REQ: begin
                    if (abort_i) begin
                        r_abort_pend <= 1'b1;
                    end
                    if (req_ready_i) begin
                        r_cfg.bytes <= CFG_BYTES_W'(w_rem_after);
                        if (!r_cfg.mode) begin
                            r_cfg.addr <= r_cfg.addr + CFG_ADDR_W'(r_consumed);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_burst_streamer.sv
// Self-checking bench for dma_burst_streamer against a descriptor-level model.
module tb_dma_burst_streamer;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [AW-1:0] cfg_addr_i = '0;
    logic [BW-1:0] cfg_bytes_i = '0;
    logic          cfg_mode_i = 1'b0;
    logic [7:0]    cfg_max_alen_i = '0;
    logic          req_valid_o;
    logic          req_ready_i = 1'b0;
    logic [AW-1:0] req_addr_o;
    logic [7:0]    req_alen_o;
    logic [2:0]    req_size_o;
    logic [SW-1:0] req_strb_o;
    logic          req_mode_o;
    logic          busy_o;
    logic          done_o;
    logic          err_cfg_o;

    always #5 clk = ~clk;

    dma_burst_streamer #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .BYTES_WIDTH (BW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .cfg_addr_i     (cfg_addr_i),
        .cfg_bytes_i    (cfg_bytes_i),
        .cfg_mode_i     (cfg_mode_i),
        .cfg_max_alen_i (cfg_max_alen_i),
        .req_valid_o    (req_valid_o),
        .req_ready_i    (req_ready_i),
        .req_addr_o     (req_addr_o),
        .req_alen_o     (req_alen_o),
        .req_size_o     (req_size_o),
        .req_strb_o     (req_strb_o),
        .req_mode_o     (req_mode_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_cfg_o      (err_cfg_o)
    );

    int tests  = 0;
    int failed = 0;

    logic [AW-1:0] q_addr[$];
    logic [7:0]    q_alen[$];
    logic [SW-1:0] q_strb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected burst list: repeatedly take as many whole beats as allowed by
    // the remaining bytes, the max burst length and the 4KB / 16-beat limit;
    // leftover bytes smaller than a beat form a final single-beat burst.
    function automatic void build_model(input logic [AW-1:0] addr, input logic [BW-1:0] bytes,
                                        input logic mode, input logic [7:0] max_alen);
        longint rem   = longint'(bytes);
        longint a     = longint'(addr);
        longint beats;
        longint lim;
        q_addr.delete();
        q_alen.delete();
        q_strb.delete();
        if ((a % SW) != 0) return;
        while (rem > 0) begin
            if (rem < SW) begin
                q_addr.push_back(AW'(a));
                q_alen.push_back(8'd0);
                q_strb.push_back(SW'((1 << rem) - 1));
                rem = 0;
            end else begin
                beats = rem / SW;
                if (longint'(max_alen) + 1 < beats) beats = longint'(max_alen) + 1;
                lim = mode ? 16 : (4096 - (a % 4096)) / SW;
                if (lim < beats) beats = lim;
                q_addr.push_back(AW'(a));
                q_alen.push_back(8'(beats - 1));
                q_strb.push_back({SW{1'b1}});
                rem = rem - beats * SW;
                if (!mode) a = (a + beats * SW) % (64'd1 << AW);
            end
        end
    endfunction

    // Run one descriptor to completion; pct is the ready probability, hold5
    // instead stalls every burst for exactly five valid cycles.
    task automatic run_transfer(input string name, input logic [AW-1:0] addr, input logic [BW-1:0] bytes,
                                input logic mode, input logic [7:0] max_alen, input int pct, input bit hold5);
        int            cyc = 0;
        int            hs_cyc = -1;
        int            wait_cnt = 0;
        int            nburst = 0;
        bit            done_seen = 0;
        bit            holding = 0;
        logic [AW-1:0] h_addr = '0;
        logic [7:0]    h_alen = '0;
        logic [SW-1:0] h_strb = '0;
        bit            exp_err;
        build_model(addr, bytes, mode, max_alen);
        exp_err = ((addr % SW) != 0);
        @(posedge clk); #1;
        start_i        = 1'b1;
        cfg_addr_i     = addr;
        cfg_bytes_i    = bytes;
        cfg_mode_i     = mode;
        cfg_max_alen_i = max_alen;
        @(posedge clk); #1;
        start_i = 1'b0;
        while (cyc < 2000) begin
            if (hold5) req_ready_i = (wait_cnt >= 5);
            else       req_ready_i = ($urandom_range(0, 99) < pct);
            @(negedge clk);
            cyc++;
            if (holding) check({name, "_valid_held"}, req_valid_o, 1);
            if (done_o) begin
                done_seen = 1;
                break;
            end
            if (req_valid_o) begin
                if (holding) begin
                    check({name, "_stable_addr"}, req_addr_o, h_addr);
                    check({name, "_stable_alen"}, req_alen_o, h_alen);
                    check({name, "_stable_strb"}, req_strb_o, h_strb);
                end else if (hs_cyc >= 0) begin
                    check({name, "_latency"}, cyc - hs_cyc, 2);
                end
                if (req_ready_i) begin
                    $display("[TB] %s burst %0d addr=0x%08h alen=%0d strb=0x%0h", name, nburst,
                             req_addr_o, req_alen_o, req_strb_o);
                    if (q_addr.size() == 0) begin
                        check({name, "_extra_burst"}, 1, 0);
                    end else begin
                        check({name, "_addr"}, req_addr_o, q_addr.pop_front());
                        check({name, "_alen"}, req_alen_o, q_alen.pop_front());
                        check({name, "_strb"}, req_strb_o, q_strb.pop_front());
                        check({name, "_mode"}, req_mode_o, mode);
                        check({name, "_size"}, req_size_o, $clog2(SW));
                    end
                    nburst++;
                    holding  = 0;
                    wait_cnt = 0;
                    hs_cyc   = cyc;
                end else begin
                    holding  = 1;
                    h_addr   = req_addr_o;
                    h_alen   = req_alen_o;
                    h_strb   = req_strb_o;
                    wait_cnt++;
                end
            end
            @(posedge clk); #1;
        end
        check({name, "_done_seen"}, done_seen, 1);
        check({name, "_missing_bursts"}, q_addr.size(), 0);
        check({name, "_err_cfg"}, err_cfg_o, exp_err);
        @(posedge clk); #1;
        req_ready_i = 1'b0;
        @(negedge clk);
        check({name, "_done_one_cycle"}, done_o, 0);
        check({name, "_idle_busy"}, busy_o, 0);
        $display("[TB] %s addr=0x%08h bytes=%0d mode=%0d max_alen=%0d bursts=%0d", name, addr, bytes,
                 mode, max_alen, nburst);
    endtask

    initial begin
        bit seen_valid;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_valid", req_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_cfg_o, 0);
        check("rst_addr", req_addr_o, 0);
        check("rst_size", req_size_o, 0);
        #2 rst = 1'b1;

        // Directed cases.
        run_transfer("split4k", 32'h0FF0, 64, 1'b0, 8'd255, 100, 0);
        run_transfer("tail", 32'h0100, 10, 1'b0, 8'd255, 100, 0);
        run_transfer("maxlen", 32'h0000, 128, 1'b0, 8'd15, 100, 0);
        run_transfer("fixed", 32'h0020, 80, 1'b1, 8'd255, 100, 0);
        run_transfer("bp5", 32'h0FF0, 70, 1'b0, 8'd7, 0, 1);
        run_transfer("zero", 32'h0200, 0, 1'b0, 8'd15, 100, 0);
        run_transfer("misalign", 32'h0102, 16, 1'b0, 8'd15, 100, 0);
        check("err_sticky", err_cfg_o, 1);
        run_transfer("err_clear", 32'h0300, 8, 1'b0, 8'd15, 100, 0);
        run_transfer("wrap", 32'hFFFF_FFF0, 40, 1'b0, 8'd255, 70, 0);

        // Abort while a request is waiting for ready.
        @(posedge clk); #1;
        start_i = 1'b1; cfg_addr_i = 32'h0; cfg_bytes_i = 128; cfg_mode_i = 1'b0; cfg_max_alen_i = 8'd15;
        req_ready_i = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int i = 0; i < 20 && !req_valid_o; i++) begin
            @(posedge clk); #1;
        end
        check("abrq_valid", req_valid_o, 1);
        abort_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abrq_held", req_valid_o, 1);
            check("abrq_addr", req_addr_o, 0);
            @(posedge clk); #1;
        end
        req_ready_i = 1'b1;
        @(posedge clk); #1;
        req_ready_i = 1'b0;
        abort_i     = 1'b0;
        @(negedge clk);
        check("abrq_done", done_o, 1);
        check("abrq_no_valid", req_valid_o, 0);
        seen_valid = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (req_valid_o) seen_valid = 1;
        end
        check("abrq_no_more", seen_valid, 0);
        check("abrq_busy", busy_o, 0);
        $display("[TB] abort_req done");

        // Abort during the burst calculation cycle (ignored in IDLE).
        @(posedge clk); #1;
        start_i = 1'b1; abort_i = 1'b1; cfg_addr_i = 32'h40; cfg_bytes_i = 32;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        check("abcalc_busy", busy_o, 1);
        check("abcalc_valid0", req_valid_o, 0);
        @(negedge clk);
        check("abcalc_done", done_o, 1);
        check("abcalc_valid1", req_valid_o, 0);
        #2 abort_i = 1'b0;
        @(negedge clk);
        check("abcalc_idle", busy_o, 0);
        $display("[TB] abort_calc done");

        // Reset in the middle of a request.
        @(posedge clk); #1;
        start_i = 1'b1; cfg_addr_i = 32'h80; cfg_bytes_i = 64; cfg_mode_i = 1'b0; cfg_max_alen_i = 8'd3;
        req_ready_i = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int i = 0; i < 20 && !req_valid_o; i++) begin
            @(posedge clk); #1;
        end
        check("rstreq_valid_before", req_valid_o, 1);
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        check("rstreq_valid", req_valid_o, 0);
        check("rstreq_busy", busy_o, 0);
        check("rstreq_done", done_o, 0);
        check("rstreq_addr", req_addr_o, 0);
        check("rstreq_alen", req_alen_o, 0);
        check("rstreq_strb", req_strb_o, 0);
        @(negedge clk); #2;
        rst = 1'b1;
        $display("[TB] reset_mid_req done");
        run_transfer("after_rst", 32'h0080, 64, 1'b0, 8'd3, 100, 0);

        // Randomised descriptors.
        for (int t = 0; t < 10; t++) begin
            logic [AW-1:0] ra;
            ra = AW'($urandom_range(0, 8191)) & ~AW'(SW - 1);
            run_transfer($sformatf("rand%0d", t), ra, BW'($urandom_range(0, 700)),
                         1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                         int'($urandom_range(30, 100)), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
